// File: rtl/stk_pipe_mem_bank_array.sv
// stk_pipe_mem_bank_array: banked single-port memory with self-initialising sweep,
// per-word even parity and a 1- or 2-cycle registered read path.
// Each bank lives in stk_pipe_mem_bank; the top owns the init FSM shared by all banks.

// One bank: storage, access qualification and the read pipeline.
module stk_pipe_mem_bank #(
  parameter int              LINES_N   = 64,
  parameter int              W         = 16,
  parameter int              RD_LAT    = 1,
  parameter int              PARITY_EN = 1,
  parameter logic [W-1:0]    INIT_VAL  = '0,
  localparam int             AW        = $clog2(LINES_N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          run,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic          ce,
  input  logic          we,
  input  logic          perr_inj,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          vld,
  output logic          perr
);
  // Addresses past LINES_N only exist when the depth is not a power of two.
  localparam bit POW2 = (LINES_N == (1 << AW));

  // Word layout: {parity, data}.
  logic [W:0]           mem [LINES_N];
  logic                 addr_ok;
  logic                 wr;
  logic                 rd;
  logic [RD_LAT:1]      vld_pipe;
  logic [RD_LAT:1][W:0] dat_pipe;

  assign addr_ok = POW2 || (32'(addr) < 32'(LINES_N));
  assign wr      = run & ce & we & addr_ok;
  assign rd      = run & ce & ~we & addr_ok;

  // Storage is not reset; the sweep and normal writes share the single port
  // (they never overlap since requests are gated until the sweep is done).
  always_ff @(posedge clk) begin
    if (init_we)
      mem[init_addr] <= {^INIT_VAL, INIT_VAL};
    else if (wr)
      mem[addr] <= {(^din) ^ perr_inj, din};
  end

  // Read pipeline: stage 1 samples the array, stage 2 (RD_LAT=2) is a plain
  // output register. Data stages load only with a valid word so outputs hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int s = RD_LAT; s >= 2; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
      vld_pipe[1] <= rd;
      if (rd) dat_pipe[1] <= mem[addr];
    end
  end

  assign dout = dat_pipe[RD_LAT][W-1:0];
  assign vld  = vld_pipe[RD_LAT];
  assign perr = (PARITY_EN != 0) && ((^dat_pipe[RD_LAT][W-1:0]) != dat_pipe[RD_LAT][W]);

  a_addr_range: assert property (@(posedge clk) disable iff (!arst_n)
    !(run && ce && !addr_ok))
    else $error("illegal address %0d in bank access", addr);

endmodule

// Top: init sweep FSM plus the bank array.
module stk_pipe_mem_bank_array #(
  parameter int           BANKS_N   = 4,
  parameter int           LINES_N   = 64,
  parameter int           W         = 16,
  parameter int           RD_LAT    = 1,
  parameter int           INIT_EN   = 1,
  parameter logic [W-1:0] INIT_VAL  = '0,
  parameter int           PARITY_EN = 1,
  localparam int          AW        = $clog2(LINES_N)
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [BANKS_N-1:0]          i_ce,
  input  logic [BANKS_N-1:0]          i_we,
  input  logic [BANKS_N-1:0][AW-1:0]  i_addr,
  input  logic [BANKS_N-1:0][W-1:0]   i_din,
  input  logic [BANKS_N-1:0]          i_perr_inj,
  output logic [BANKS_N-1:0][W-1:0]   o_dout,
  output logic [BANKS_N-1:0]          o_vld,
  output logic [BANKS_N-1:0]          o_perr,
  output logic                        o_init_done
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          init_done;
  logic          init_we;

  // Sweep INIT_VAL through every line after reset; init_done rises with the last write.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
      cnt       <= '0;
      init_done <= (INIT_EN == 0);
    end else if (state == S_INIT) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(LINES_N - 1)) begin
        state     <= S_RUN;
        init_done <= 1'b1;
      end
    end
  end

  assign init_we     = (state == S_INIT);
  assign o_init_done = init_done;

  for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
    stk_pipe_mem_bank #(
      .LINES_N   (LINES_N),
      .W         (W),
      .RD_LAT    (RD_LAT),
      .PARITY_EN (PARITY_EN),
      .INIT_VAL  (INIT_VAL)
    ) u_bank (
      .clk       (clk),
      .arst_n    (arst_n),
      .run       (init_done),
      .init_we   (init_we),
      .init_addr (cnt),
      .ce        (i_ce[b]),
      .we        (i_we[b]),
      .perr_inj  (i_perr_inj[b]),
      .addr      (i_addr[b]),
      .din       (i_din[b]),
      .dout      (o_dout[b]),
      .vld       (o_vld[b]),
      .perr      (o_perr[b])
    );
  end

  // Requests during the sweep are dropped; flag them so the source gets fixed.
  a_ce_in_init: assert property (@(posedge clk) disable iff (!arst_n)
    !(!init_done && (|i_ce)))
    else $warning("i_ce seen while init sweep in progress; request dropped");

endmodule

// File: tb/tb_stk_pipe_mem_bank_array.sv
// Bench for stk_pipe_mem_bank_array: two instances (RD_LAT=1/INIT_VAL=0 and
// RD_LAT=2/INIT_VAL=A5A5) driven identically and compared each cycle against
// an array-based memory model with a time-indexed expected-read record.
module tb_stk_pipe_mem_bank_array;
  localparam int B = 4;
  localparam int L = 64;
  localparam int W = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [B-1:0]        i_ce = '0, i_we = '0, i_perr_inj = '0;
  logic [B-1:0][5:0]   i_addr = '0;
  logic [B-1:0][W-1:0] i_din = '0;
  logic [B-1:0][W-1:0] dout [2];
  logic [B-1:0]        vld  [2];
  logic [B-1:0]        perr [2];
  logic                done [2];

  logic [W-1:0] ivals [2];

  // model state
  logic [W-1:0] m_dat [2][B][L];
  logic         m_pe  [2][B][L];
  logic [B-1:0] r_v   [4];
  logic [W-1:0] r_dat [4][2][B];
  logic         r_pe  [4][2][B];
  logic [W-1:0] last_dat [2][B];
  logic         last_pe  [2][B];
  int n = 0, since = -1, checks = 0, errors = 0;

  always #5 clk = ~clk;

  stk_pipe_mem_bank_array #(.BANKS_N(B), .LINES_N(L), .W(W), .RD_LAT(1), .INIT_EN(1),
    .INIT_VAL(16'h0000), .PARITY_EN(1)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .i_ce(i_ce), .i_we(i_we), .i_addr(i_addr), .i_din(i_din),
    .i_perr_inj(i_perr_inj), .o_dout(dout[0]), .o_vld(vld[0]), .o_perr(perr[0]),
    .o_init_done(done[0]));

  stk_pipe_mem_bank_array #(.BANKS_N(B), .LINES_N(L), .W(W), .RD_LAT(2), .INIT_EN(1),
    .INIT_VAL(16'hA5A5), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .i_ce(i_ce), .i_we(i_we), .i_addr(i_addr), .i_din(i_din),
    .i_perr_inj(i_perr_inj), .o_dout(dout[1]), .o_vld(vld[1]), .o_perr(perr[1]),
    .o_init_done(done[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Reset drops in-flight reads and outputs; the sweep will leave every word at INIT_VAL.
  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < B; b++) begin
        last_dat[d][b] = '0;
        last_pe[d][b]  = 1'b0;
        for (int a = 0; a < L; a++) begin
          m_dat[d][b][a] = ivals[d];
          m_pe[d][b][a]  = 1'b0;
        end
      end
    for (int i = 0; i < 4; i++) r_v[i] = '0;
  endtask

  task automatic check_outputs();
    logic exp_done;
    int   idx;
    exp_done = (since >= L);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d init_done", d), 32'(done[d]), 32'(exp_done));
      idx = (n + 4 - (d + 1)) % 4;
      for (int b = 0; b < B; b++) begin
        if (r_v[idx][b]) begin
          last_dat[d][b] = r_dat[idx][d][b];
          last_pe[d][b]  = r_pe[idx][d][b];
        end
        chk($sformatf("d%0d b%0d vld", d, b),  32'(vld[d][b]),  32'(r_v[idx][b]));
        chk($sformatf("d%0d b%0d dout", d, b), 32'(dout[d][b]), 32'(last_dat[d][b]));
        chk($sformatf("d%0d b%0d perr", d, b), 32'(perr[d][b]), 32'(last_pe[d][b]));
      end
    end
  endtask

  // One clock: check outputs, then drive this cycle's request (or reset) and update the model.
  task automatic cycle(input logic rst, input logic [B-1:0] c, input logic [B-1:0] w,
                       input logic [B-1:0] j, input logic [B-1:0][5:0] a,
                       input logic [B-1:0][W-1:0] dd);
    @(negedge clk);
    n++;
    if (arst_n) since++;
    check_outputs();
    r_v[n % 4] = '0;
    i_ce = c; i_we = w; i_perr_inj = j; i_addr = a; i_din = dd;
    if (rst) begin
      arst_n = 1'b0;
      since  = -1;
      model_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d rst vld", d),  32'(vld[d]), 32'(0));
        chk($sformatf("d%0d rst done", d), 32'(done[d]), 32'(0));
        chk($sformatf("d%0d rst dout0", d), 32'(dout[d][0]), 32'(0));
      end
    end else begin
      if (!arst_n) begin
        arst_n = 1'b1;
        since  = 0;
      end
      if (since >= L)
        for (int b = 0; b < B; b++)
          if (c[b]) begin
            for (int d = 0; d < 2; d++)
              if (w[b]) begin
                m_dat[d][b][a[b]] = dd[b];
                m_pe[d][b][a[b]]  = j[b];
              end else begin
                r_dat[n % 4][d][b] = m_dat[d][b][a[b]];
                r_pe[n % 4][d][b]  = m_pe[d][b][a[b]];
              end
            if (!w[b]) r_v[n % 4][b] = 1'b1;
          end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, '0, '0, '0);
  endtask

  // Release reset and ride out the sweep, poking a write into all banks at cycle 10.
  task automatic run_init(input logic [5:0] pa, input logic [W-1:0] pv);
    for (int i = 0; i < L; i++)
      if (i == 10) cycle(1'b0, 4'hF, 4'hF, '0, {B{pa}}, {B{pv}});
      else         cycle(1'b0, '0, '0, '0, '0, '0);
    cycle(1'b0, 4'hF, 4'h0, '0, {B{pa}}, '0);
    idle(2);
  endtask

  task automatic rand_ops(input int k);
    logic [B-1:0][5:0]   a;
    logic [B-1:0][W-1:0] dd;
    logic [B-1:0]        j;
    for (int i = 0; i < k; i++) begin
      for (int b = 0; b < B; b++) begin
        a[b]  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, L-1));
        dd[b] = W'($urandom);
      end
      j = ($urandom_range(0, 7) == 0) ? B'($urandom) : '0;
      cycle(1'b0, B'($urandom), B'($urandom), j, a, dd);
    end
  endtask

  initial begin
    ivals[0] = 16'h0000;
    ivals[1] = 16'hA5A5;
    model_reset();
    repeat (3) cycle(1'b1, '0, '0, '0, '0, '0);
    run_init(6'd3, 16'hDEAD);
    // full sweep read, all banks, back to back
    for (int a = 0; a < L; a++) cycle(1'b0, 4'hF, 4'h0, '0, {B{6'(a)}}, '0);
    idle(3);
    // write then read next cycle
    cycle(1'b0, 4'h1, 4'h1, '0, {B{6'd5}}, {B{16'hBEEF}});
    cycle(1'b0, 4'h1, 4'h0, '0, {B{6'd5}}, '0);
    idle(3);
    // parity injection, then clean rewrite
    cycle(1'b0, 4'hF, 4'hF, 4'hF, {B{6'd7}}, {B{16'h1234}});
    cycle(1'b0, 4'hF, 4'h0, '0, {B{6'd7}}, '0);
    idle(2);
    cycle(1'b0, 4'hF, 4'hF, '0, {B{6'd7}}, {B{16'h1234}});
    cycle(1'b0, 4'hF, 4'h0, '0, {B{6'd7}}, '0);
    idle(3);
    rand_ops(1500);
    // reset with reads in flight
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'hF, 4'h0, '0, {B{6'(i + 5)}}, '0);
    repeat (2) cycle(1'b1, 4'hF, 4'h0, '0, {B{6'd5}}, '0);
    run_init(6'd12, 16'h5555);
    rand_ops(600);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
